shift_rows_pipe: RTL and testbench

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/shift_rows_pipe.sv | 163 ++++++++++++++++
 tb/tb_shift_rows_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: AES ShiftRows / InvShiftRows / bypass stage for one to four
// independent 128-bit states per transfer. The transform is applied when a
// transfer is accepted, and the result is stored in a two-entry elastic
// buffer. The head entry drives Output and mode_err directly from registers.
// A wrapping counter tracks the number of accepted input transfers.
module shift_rows_pipe #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [128*LANES-1:0]   Input,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [128*LANES-1:0]   Output,
  output logic                   mode_err,
  output logic [CNT_W-1:0]       blk_cnt
);

  localparam int DW = 128 * LANES;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  state_t           state_r;
  logic [DW-1:0]    head_data_r;
  logic             head_err_r;
  logic [DW-1:0]    tail_data_r;
  logic             tail_err_r;
  logic [CNT_W-1:0] blk_cnt_r;

  logic [DW-1:0]    xform_s;
  logic             new_err_s;
  logic             accept_s;
  logic             pop_s;

  // Row rotation of one column-major AES state. Byte i = 4c+r sits at
  // bits [127-8i:120-8i]. Mode 00 rotates row r left by r positions.
  // Mode 01 rotates it right by r positions. Every other mode passes the
  // state through unchanged.
  function automatic logic [127:0] shift_lane(input logic [127:0] d,
                                              input logic [1:0]   m);
    logic [127:0] q;
    logic [1:0]   src_c;
    logic [1:0]   col;
    logic [1:0]   row;
    q = d;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        col = c[1:0];
        row = r[1:0];
        case (m)
          2'b00:   src_c = col + row;
          2'b01:   src_c = col - row;
          default: src_c = col;
        endcase
        q[127 - 8*(4*c + r) -: 8] = d[127 - 8*(4*int'(src_c) + r) -: 8];
      end
    end
    return q;
  endfunction

  // Handshake decode; in_ready depends only on registered state and on rst.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = (state_r != TWO);
    end
    if (state_r != EMPTY) begin
      out_valid = 1'b1;
    end else begin
      out_valid = 1'b0;
    end
  end

  assign accept_s = in_valid && in_ready;
  assign pop_s    = out_valid && out_ready;

  // Per-lane transform of the presented input using the presented mode.
  // Storing the result at accept time latches the mode with its data.
  always_comb begin
    xform_s = {DW{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      xform_s[128*k +: 128] = shift_lane(Input[128*k +: 128], mode);
    end
    if (mode == 2'b11) begin
      new_err_s = 1'b1;
    end else begin
      new_err_s = 1'b0;
    end
  end

  // Two-entry buffer FSM plus the accepted-block counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      head_data_r <= {DW{1'b0}};
      head_err_r  <= 1'b0;
      tail_data_r <= {DW{1'b0}};
      tail_err_r  <= 1'b0;
      blk_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        blk_cnt_r <= blk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        blk_cnt_r <= blk_cnt_r;
      end
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            head_data_r <= xform_s;
            head_err_r  <= new_err_s;
            state_r     <= ONE;
          end else begin
            state_r <= EMPTY;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            // The old head leaves as the new entry arrives and replaces it.
            head_data_r <= xform_s;
            head_err_r  <= new_err_s;
            state_r     <= ONE;
          end else if (accept_s) begin
            tail_data_r <= xform_s;
            tail_err_r  <= new_err_s;
            state_r     <= TWO;
          end else if (pop_s) begin
            state_r <= EMPTY;
          end else begin
            state_r <= ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            head_data_r <= tail_data_r;
            head_err_r  <= tail_err_r;
            state_r     <= ONE;
          end else begin
            state_r <= TWO;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign Output   = head_data_r;
  assign mode_err = head_err_r;
  assign blk_cnt  = blk_cnt_r;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe. A single-lane instance with a 16-bit
// counter and a dual-lane instance with a 4-bit counter share all control
// inputs. On the dual-lane instance, lane1 carries the same state as the
// single-lane instance and lane0 is held at zero.
module tb_shift_rows_pipe;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [1:0]   mode;
  logic [127:0] din_a;
  logic [255:0] din_b;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, mode_err_a;
  logic [127:0] out_a;
  logic [15:0]  blk_a;
  logic         in_ready_b, out_valid_b, mode_err_b;
  logic [255:0] out_b;
  logic [3:0]   blk_b;

  int n_tests;
  int n_fail;

  assign din_b = {din_a, 128'h0};

  shift_rows_pipe #(.LANES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .mode(mode), .Input(din_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .Output(out_a), .mode_err(mode_err_a), .blk_cnt(blk_a)
  );

  shift_rows_pipe #(.LANES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .mode(mode), .Input(din_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .Output(out_b), .mode_err(mode_err_b), .blk_cnt(blk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] din;
    logic [127:0] exp;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [127:0] A_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_SR  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] A_ISR = 128'h000d0a0704010e0b0805020f0c090603;

  initial begin
    n_tests = 0;
    n_fail = 0;
    vecs[0] = '{2'b00, 128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0};
    vecs[1] = '{2'b01, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0};
    vecs[2] = '{2'b10, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0};
    vecs[3] = '{2'b11, A_IN, A_IN, 1'b1};
    vecs[4] = '{2'b00, A_IN, A_SR, 1'b0};
    vecs[5] = '{2'b01, A_IN, A_ISR, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    mode = 2'b00;
    din_a = 128'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {255'd0, in_ready_a}, 256'd0);
    check("rst_out_valid", {255'd0, out_valid_a}, 256'd0);
    check("rst_blk_cnt", {240'd0, blk_a}, 256'd0);
    check("rst_output", {128'd0, out_a}, 256'd0);
    check("rst_mode_err", {255'd0, mode_err_a}, 256'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {255'd0, in_ready_a}, 256'd1);

    // Table vectors streamed back-to-back with out_ready held high
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("tbl_out_valid", {255'd0, out_valid_a}, 256'd1);
        check("tbl_output", {128'd0, out_a}, {128'd0, vecs[i-1].exp});
        check("tbl_mode_err", {255'd0, mode_err_a}, {255'd0, vecs[i-1].exp_err});
        check("tbl_blk_cnt", {240'd0, blk_a}, 256'(i));
        check("tbl_lanes_b", out_b, {vecs[i-1].exp, 128'h0});
        check("tbl_mode_err_b", {255'd0, mode_err_b}, {255'd0, vecs[i-1].exp_err});
      end
      if (i < 6) begin
        in_valid = 1'b1;
        mode = vecs[i].mode;
        din_a = vecs[i].din;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Backpressure: A and B fill the buffer, C waits until space frees up.
    do_reset();
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b00; din_a = A_IN;
    @(negedge clk);
    mode = 2'b01;
    @(negedge clk);
    mode = 2'b10;
    #1;
    check("bp_in_ready_full", {255'd0, in_ready_a}, 256'd0);
    check("bp_head_a", {128'd0, out_a}, {128'd0, A_SR});
    @(negedge clk);
    check("bp_blk_hold", {240'd0, blk_a}, 256'd2);
    check("bp_head_stable", {128'd0, out_a}, {128'd0, A_SR});
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_head_b", {128'd0, out_a}, {128'd0, A_ISR});
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_head_c", {128'd0, out_a}, {128'd0, A_IN});
    check("bp_blk_cnt", {240'd0, blk_a}, 256'd3);
    @(negedge clk);
    check("bp_drained", {255'd0, out_valid_a}, 256'd0);

    // Reset while the buffer is full
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; mode = 2'b00; din_a = A_IN;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("full_before_rst", {255'd0, in_ready_a}, 256'd0);
    rst = 1'b1;
    #1;
    check("in_ready_in_rst", {255'd0, in_ready_a}, 256'd0);
    @(negedge clk);
    check("rst_mid_out_valid", {255'd0, out_valid_a}, 256'd0);
    check("rst_mid_blk_cnt", {240'd0, blk_a}, 256'd0);
    check("rst_mid_output", {128'd0, out_a}, 256'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_mid_in_ready_after", {255'd0, in_ready_a}, 256'd1);
    @(negedge clk);
    check("rst_no_partial", {255'd0, out_valid_a}, 256'd0);

    // Counter wrap: 17 transfers
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      mode = 2'b10;
      din_a = 128'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("wrap_blk_a", {240'd0, blk_a}, 256'd17);
    check("wrap_blk_b", {252'd0, blk_b}, 256'd1);
    check("wrap_last_out", {128'd0, out_a}, 256'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
